aer_spike_encoder: RTL
======================

// Module: aer_spike_encoder
// PURPOSE
//  Converts one timestep's parallel spike vector from a neuron layer into a serial
//  stream of address events (AER), lowest index first, one address per handshake.
//  Sits directly upstream of parameterized_decoder: addr_out drives its `in`, and
//  (addr_vld & addr_rdy) drives its `en`, so the one-hot selects the target row.
// PARAMETERS
//  N      8            number of neurons / spike lines (any N >= 2, not only powers of 2)
//  M      $clog2(N)    localparam; address width, matches the decoder's M
//  CNT_W  $clog2(N+1)  localparam; width of the per-frame spike count (holds 0..N)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  spike_vld    in   1      spike_in valid (timestep strobe)
//  spike_in     in   N      spike vector, bit i = neuron i fired
//  spike_rdy    out  1      encoder idle, accepts a new vector
//  addr_out     out  M      address of current pending spike
//  addr_vld     out  1      addr_out valid
//  addr_rdy     in   1      downstream accepts addr_out
//  busy         out  1      frame in progress (SCAN or DONE)
//  done         out  1      1-cycle pulse: frame fully drained
//  spike_count  out  CNT_W  addresses emitted in current/last frame
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, pending=0, spike_count=0.
//    Outputs while/after reset: addr_vld=0, addr_out=0, done=0, busy=0, spike_rdy=1.
//  - FSM with states IDLE, SCAN, DONE. All outputs decode from registers only; there is
//    no combinational path from any input to any output.
//  - IDLE: spike_rdy=1.
//    On spike_vld: pending<=spike_in, spike_count<=0.
//    Next state is SCAN if spike_in!=0, else DONE.
//  - SCAN: addr_vld=1; addr_out = index of lowest set bit of pending.
//    On addr_rdy: clear that bit and spike_count++.
//    If it was the last set bit, go to DONE; otherwise stay in SCAN. Throughput is one
//    address per cycle.
//  - Back-pressure: while addr_vld & !addr_rdy, addr_out and pending hold stable.
//  - DONE: done=1 for exactly one cycle, addr_vld=0. spike_count is final; go to IDLE.
//  - spike_count holds its value until the next vector is accepted.
//  - Latency: vector accepted at edge t, first addr_vld at t+1.
//    Done pulse occurs in the cycle after the last handshake.
//    Zero vector: done in cycle t+1.
//  - spike_rdy=0 outside IDLE. spike_vld in SCAN/DONE is ignored and the vector dropped
//    (the producer must wait for spike_rdy).
//  - busy = (state != IDLE).
//  - Bits of spike_in above N-1 do not exist. addr_out never exceeds N-1, including for
//    non-power-of-2 N.
//  - Reset mid-SCAN: pending frame discarded; returns to the reset values above, with no
//    done pulse.
// TESTING
//  1. N=8, spike_in=8'b1010_0100, addr_rdy=1 -> addr_out 2,5,7 on cycles t+1..t+3;
//     done at t+4; spike_count=3.
//  2. Same vector, addr_rdy=0 for cycles t+1..t+3 -> addr_out=2, addr_vld=1 held;
//     then 2,5,7 resume with no loss or duplication.
//  3. spike_in=8'h00 -> addr_vld never asserts; done at t+1; spike_count=0;
//     spike_rdy=1 at t+2.
//  4. spike_in=8'hFF -> addresses 0..7 back-to-back; done at t+9; spike_count=8
//     (CNT_W=4, no wrap).
//  5. spike_vld pulsed during SCAN with 8'h01 -> ignored, original frame completes
//     unchanged. Separately, rst_n low mid-SCAN -> addr_vld=0 immediately, no done;
//     the next frame encodes correctly.
//  6. N=5, spike_in=5'b10001 -> addr_out 0 then 4; done pulse; spike_count=2.
//     Also check the decoder output one-hot is 00001 then 10000.

Source files
------------

// File: rtl/aer_spike_encoder.sv
// Serialises one timestep's spike vector into address events, lowest index first.
// Latency: vector accepted at edge t, first address valid in the next cycle, done one cycle after the last handshake.
// Backpressure: addr_out/pending hold while addr_vld & !addr_rdy; spike_rdy low (vector dropped) outside IDLE.
module aer_spike_encoder #(
    parameter  int N     = 8,
    localparam int M     = $clog2(N),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_vld,
    input  logic [N-1:0]     spike_in,
    output logic             spike_rdy,
    output logic [M-1:0]     addr_out,
    output logic             addr_vld,
    input  logic             addr_rdy,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] spike_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     pending;
    logic [N-1:0]     pending_clr;
    logic [M-1:0]     low_idx;
    logic             accept;
    logic             fire;

    // Priority encode from the top down so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = M'(i);
            end
        end
    end

    assign pending_clr = pending & (pending - N'(1));
    assign accept      = (state == IDLE) && spike_vld;
    assign fire        = (state == SCAN) && addr_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (spike_vld) begin
                    state_nxt = (|spike_in) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (addr_rdy && (pending_clr == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            spike_count <= '0;
        end else if (accept) begin
            pending     <= spike_in;
            spike_count <= '0;
        end else if (fire) begin
            pending     <= pending_clr;
            spike_count <= spike_count + CNT_W'(1);
        end
    end

    // Outputs decode only from state and pending, never from inputs.
    always_comb begin
        spike_rdy = (state == IDLE);
        addr_vld  = (state == SCAN);
        done      = (state == DONE);
        busy      = (state != IDLE);
        addr_out  = (state == SCAN) ? low_idx : '0;
    end

endmodule
